fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the cpu core. Reads 16-bit instructions from byte-wide synchronous program memory at 12-bit byte addresses, two reads per instruction, big-endian. Presents each instruction and its address over a valid/ready handshake. Redirects on branch requests from the core.

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, reset address and fetch state encoding
package fetch_unit_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;
  localparam int INS_W_DEF  = 2 * DATA_W_DEF;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 12'h000;

  typedef enum logic [1:0] {
    S_HI   = 2'd0,
    S_LO   = 2'd1,
    S_CAP  = 2'd2,
    S_WAIT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - program memory port plus instruction handshake toward the core
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int INS_W  = INS_W_DEF
);

  logic              mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              halt_i;
  logic              branch_i;
  logic [ADDR_W-1:0] branch_addr_i;
  logic [INS_W-1:0]  ins_o;
  logic [ADDR_W-1:0] pc_o;
  logic              ins_valid_o;
  logic              ins_ready_i;

  modport master (
    output mem_rd_o, mem_addr_o, ins_o, pc_o, ins_valid_o,
    input  mem_data_i, halt_i, branch_i, branch_addr_i, ins_ready_i
  );

  modport slave (
    input  mem_rd_o, mem_addr_o, ins_o, pc_o, ins_valid_o,
    output mem_data_i, halt_i, branch_i, branch_addr_i, ins_ready_i
  );

endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - two-byte big-endian instruction fetch with branch redirect and halt
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int INS_W  = INS_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input logic         clk_i,
  input logic         rst_i,
  fetch_unit_if.master bus
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [INS_W-1:0]  ins_q, ins_d;
  logic              valid_q, valid_d;

  logic              free;
  logic              load;
  logic [INS_W-1:0]  load_ins;

  // Memory strobe is purely a function of state; forced quiet while reset is held.
  always_comb begin
    bus.mem_rd_o   = 1'b0;
    bus.mem_addr_o = fpc_q;
    if (rst_i) begin
      bus.mem_addr_o = '0;
    end else begin
      case (state_q)
        S_HI:    bus.mem_rd_o = !bus.halt_i;
        S_LO: begin
          bus.mem_rd_o   = 1'b1;
          bus.mem_addr_o = fpc_q | ONE;
        end
        default: bus.mem_rd_o = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    pc_d     = pc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ins_d    = ins_q;
    valid_d  = valid_q;
    load     = 1'b0;
    load_ins = '0;
    free     = !valid_q || bus.ins_ready_i;

    if (valid_q && bus.ins_ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_HI: begin
        if (!bus.halt_i) begin
          state_d = S_LO;
        end
      end
      S_LO: begin
        hi_d    = bus.mem_data_i;
        state_d = S_CAP;
      end
      S_CAP: begin
        if (free) begin
          load     = 1'b1;
          load_ins = {hi_q, bus.mem_data_i};
        end else begin
          lo_d    = bus.mem_data_i;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (free) begin
          load     = 1'b1;
          load_ins = {hi_q, lo_q};
        end
      end
      default: state_d = S_HI;
    endcase

    if (load) begin
      ins_d   = load_ins;
      pc_d    = fpc_q;
      valid_d = 1'b1;
      fpc_d   = fpc_q + TWO;
      state_d = S_HI;
    end

    // Redirect wins over everything, including a same-cycle load or transfer.
    if (bus.branch_i) begin
      fpc_d   = bus.branch_addr_i & ~ONE;
      state_d = S_HI;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_HI;
      fpc_q   <= RESET_PC;
      pc_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ins_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      pc_q    <= pc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ins_q   <= ins_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ins_o       = ins_q;
  assign bus.pc_o        = pc_q;
  assign bus.ins_valid_o = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - cycle tables, corner sequences and random scoreboard for fetch_unit
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(12), .DATA_W(8), .INS_W(16)) bus_a ();
  fetch_unit_if #(.ADDR_W(12), .DATA_W(8), .INS_W(16)) bus_b ();

  fetch_unit #(.ADDR_W(12), .DATA_W(8), .INS_W(16), .RESET_PC(12'h000)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a));
  fetch_unit #(.ADDR_W(12), .DATA_W(8), .INS_W(16), .RESET_PC(12'hFFE)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b));

  // Program memory: one byte array, a 1-cycle synchronous read port per DUT.
  logic [7:0] mem [0:4095];
  logic [7:0] rdata_a = 8'h00;
  logic [7:0] rdata_b = 8'h00;
  always @(posedge clk) begin
    if (bus_a.mem_rd_o) rdata_a <= mem[bus_a.mem_addr_o];
    if (bus_b.mem_rd_o) rdata_b <= mem[bus_b.mem_addr_o];
  end
  assign bus_a.mem_data_i = rdata_a;
  assign bus_b.mem_data_i = rdata_b;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         rst_first;
    bit         ready;
    bit         halt;
    bit         branch;
    logic [11:0] baddr;
    bit         ev;
    logic [15:0] eins;
    logic [11:0] epc;
    bit         erd;
    logic [11:0] eaddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rf, bit rdy, bit h, bit b, logic [11:0] ba, bit ev,
                              logic [15:0] ei, logic [11:0] ep, bit er, logic [11:0] ea);
    vec_t v;
    v.rst_first = rf; v.ready = rdy; v.halt = h; v.branch = b; v.baddr = ba;
    v.ev = ev; v.eins = ei; v.epc = ep; v.erd = er; v.eaddr = ea;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_a.ins_ready_i = 1'b1; bus_a.halt_i = 1'b0;
    bus_a.branch_i = 1'b0;    bus_a.branch_addr_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_out(input string tag, input bit ev, input logic [15:0] ei,
                           input logic [11:0] ep, input bit er, input logic [11:0] ea);
    check({tag, " valid"}, 32'(bus_a.ins_valid_o), 32'(ev));
    check({tag, " rd"}, 32'(bus_a.mem_rd_o), 32'(er));
    check({tag, " addr"}, 32'(bus_a.mem_addr_o), 32'(ea));
    if (ev) begin
      check({tag, " ins"}, 32'(bus_a.ins_o), 32'(ei));
      check({tag, " pc"}, 32'(bus_a.pc_o), 32'(ep));
    end
  endtask

  logic [11:0] exp_pc;
  logic [11:0] held_pc;
  logic [15:0] held_ins;
  logic [15:0] model_ins;
  bit          stall_pending;
  bit          last_branch;
  int          transfers;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h000] = 8'h12; mem[12'h001] = 8'h34; mem[12'h002] = 8'h56; mem[12'h003] = 8'h78;
    mem[12'h100] = 8'hAB; mem[12'h101] = 8'hCD; mem[12'hFFE] = 8'h9A; mem[12'hFFF] = 8'hBC;

    bus_a.ins_ready_i = 1'b1; bus_a.halt_i = 1'b0; bus_a.branch_i = 1'b0; bus_a.branch_addr_i = '0;
    bus_b.ins_ready_i = 1'b1; bus_b.halt_i = 1'b0; bus_b.branch_i = 1'b0; bus_b.branch_addr_i = '0;

    // Reset values while rst is held.
    #1;
    check("reset valid", 32'(bus_a.ins_valid_o), 32'd0);
    check("reset rd", 32'(bus_a.mem_rd_o), 32'd0);
    check("reset addr", 32'(bus_a.mem_addr_o), 32'd0);
    check("reset ins", 32'(bus_a.ins_o), 32'd0);
    check("reset pc", 32'(bus_a.pc_o), 32'd0);
    check("reset b addr", 32'(bus_b.mem_addr_o), 32'd0);

    // Straight fetch, ready held high.
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 12'h000));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 12'h001));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 16'h1234, 12'h000, 1, 12'h002));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 12'h003));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 12'h002));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 16'h5678, 12'h002, 1, 12'h004));
    // Core stalls ten cycles after the first valid.
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 12'h000));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 12'h001));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h1234, 12'h000, 1, 12'h002));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h1234, 12'h000, 1, 12'h003));
    for (int c = 5; c <= 12; c++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h1234, 12'h000, 0, 12'h002));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 16'h1234, 12'h000, 0, 12'h002));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 16'h5678, 12'h002, 1, 12'h004));
    // Halt from cycle 1, released in cycle 5.
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 12'h000));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 12'h001));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 16'h1234, 12'h000, 0, 12'h002));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 12'h002));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 12'h002));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 12'h003));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 12'h002));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 16'h5678, 12'h002, 1, 12'h004));
    // Odd branch target while fetching the low byte.
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 12'h000));
    tbl.push_back(mk(0, 1, 0, 1, 12'h101, 0, 0, 0, 1, 12'h001));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 12'h100));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 12'h101));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 12'h100));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 16'hABCD, 12'h100, 1, 12'h102));
    // Branch in a transfer cycle flushes the presented instruction.
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 12'h000));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 12'h001));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 1, 0, 1, 12'h101, 1, 16'h1234, 12'h000, 1, 12'h002));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 12'h100));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 12'h101));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 12'h100));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 16'hABCD, 12'h100, 1, 12'h102));
    // Branch while halted moves the fetch address without reading.
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 12'h000));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 12'h001));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 12'h000));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 16'h1234, 12'h000, 0, 12'h002));
    tbl.push_back(mk(0, 1, 1, 1, 12'h100, 0, 0, 0, 0, 12'h002));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 12'h100));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 12'h100));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_first) do_reset();
      else @(negedge clk);
      bus_a.ins_ready_i   = tbl[i].ready;
      bus_a.halt_i        = tbl[i].halt;
      bus_a.branch_i      = tbl[i].branch;
      bus_a.branch_addr_i = tbl[i].baddr;
      #1;
      check_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].eins, tbl[i].epc, tbl[i].erd, tbl[i].eaddr);
    end

    // Wrapping instance starting at FFE.
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c == 0) check("wrap c0 addr", 32'(bus_b.mem_addr_o), 32'h0FFE);
      if (c == 1) check("wrap c1 addr", 32'(bus_b.mem_addr_o), 32'h0FFF);
      if (c == 3) begin
        check("wrap c3 valid", 32'(bus_b.ins_valid_o), 32'd1);
        check("wrap c3 ins", 32'(bus_b.ins_o), 32'h9ABC);
        check("wrap c3 pc", 32'(bus_b.pc_o), 32'h0FFE);
        check("wrap c3 addr", 32'(bus_b.mem_addr_o), 32'h0000);
      end
      if (c == 4) begin
        check("wrap c4 valid", 32'(bus_b.ins_valid_o), 32'd0);
        check("wrap c4 addr", 32'(bus_b.mem_addr_o), 32'h0001);
      end
      if (c == 6) begin
        check("wrap c6 ins", 32'(bus_b.ins_o), 32'h1234);
        check("wrap c6 pc", 32'(bus_b.pc_o), 32'h0000);
      end
    end

    // Reset pulsed in S_CAP while an instruction is presented.
    do_reset();
    bus_a.ins_ready_i = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("midrst pre valid", 32'(bus_a.ins_valid_o), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst valid", 32'(bus_a.ins_valid_o), 32'd0);
    check("midrst rd", 32'(bus_a.mem_rd_o), 32'd0);
    check("midrst addr", 32'(bus_a.mem_addr_o), 32'd0);
    check("midrst ins", 32'(bus_a.ins_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_a.ins_ready_i = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check_out($sformatf("midrst c%0d", c), c == 3, 16'h1234, 12'h000,
                c != 2, (c == 1) ? 12'h001 : (c == 3) ? 12'h002 : 12'h000);
    end

    // Random traffic against an in-order address model.
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    do_reset();
    exp_pc = 12'h000;
    stall_pending = 1'b0;
    last_branch = 1'b0;
    transfers = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      bus_a.ins_ready_i   = ($urandom_range(0, 3) != 0);
      bus_a.halt_i        = ($urandom_range(0, 7) == 0);
      bus_a.branch_i      = !last_branch && ($urandom_range(0, 39) == 0);
      bus_a.branch_addr_i = 12'($urandom);
      last_branch = bus_a.branch_i;
      #1;
      if (stall_pending) begin
        check("rand hold valid", 32'(bus_a.ins_valid_o), 32'd1);
        check("rand hold ins", 32'(bus_a.ins_o), 32'(held_ins));
        check("rand hold pc", 32'(bus_a.pc_o), 32'(held_pc));
      end
      if (bus_a.branch_i) begin
        exp_pc = bus_a.branch_addr_i & 12'hFFE;
      end else if (bus_a.ins_valid_o && bus_a.ins_ready_i) begin
        model_ins = {mem[exp_pc], mem[exp_pc | 12'h001]};
        check("rand pc", 32'(bus_a.pc_o), 32'(exp_pc));
        check("rand ins", 32'(bus_a.ins_o), 32'(model_ins));
        exp_pc = exp_pc + 12'd2;
        transfers++;
      end
      stall_pending = bus_a.ins_valid_o && !bus_a.ins_ready_i && !bus_a.branch_i;
      held_ins = bus_a.ins_o;
      held_pc  = bus_a.pc_o;
    end
    check("rand progress", 32'(transfers >= 300), 32'd1);

    @(negedge clk);
    bus_a.branch_i = 1'b0;
    bus_a.halt_i = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
